// File: rtl/drv_teclado_pkg.sv
// Shared key codes, scan FSM states and the row/column -> key lookup for the keypad driver.
package drv_teclado_pkg;

  localparam logic [4:0] KEY_0    = 5'd0;
  localparam logic [4:0] KEY_1    = 5'd1;
  localparam logic [4:0] KEY_2    = 5'd2;
  localparam logic [4:0] KEY_3    = 5'd3;
  localparam logic [4:0] KEY_4    = 5'd4;
  localparam logic [4:0] KEY_5    = 5'd5;
  localparam logic [4:0] KEY_6    = 5'd6;
  localparam logic [4:0] KEY_7    = 5'd7;
  localparam logic [4:0] KEY_8    = 5'd8;
  localparam logic [4:0] KEY_9    = 5'd9;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'd14;
  localparam logic [4:0] KEY_HASH = 5'd15;
  localparam logic [4:0] KEY_NONE = 5'd31;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_COUNT,
    ST_HELD
  } scan_state_t;

  // Row and column are zero-based indices into the 4x4 keypad layout.
  function automatic logic [4:0] key_lookup(input logic [1:0] row, input logic [1:0] column);
    logic [4:0] code;
    code = KEY_NONE;
    case ({row, column})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/teclado_decode.sv
// Combinational keypad decode: current column drive and row sense -> key code and valid flag.
module teclado_decode
  import drv_teclado_pkg::*;
#(
  parameter logic [3:0] col_3  = 4'b0100,
  parameter logic [3:0] fila_1 = 4'b0001,
  parameter logic [3:0] col_4  = 4'b1000,
  parameter logic [3:0] fila_2 = 4'b0010,
  parameter logic [3:0] fila_3 = 4'b0100,
  parameter logic [3:0] col_1  = 4'b0001,
  parameter logic [3:0] fila_4 = 4'b1000,
  parameter logic [3:0] col_2  = 4'b0010
) (
  input  logic [3:0] col,
  input  logic [3:0] fila,
  output logic [4:0] code,
  output logic       valid
);

  logic       row_hit;
  logic [1:0] row_idx;
  logic       col_hit;
  logic [1:0] col_idx;

  // Only an exact match against one row code counts; multi-row presses fall through as invalid.
  always_comb begin
    row_hit = 1'b1;
    row_idx = 2'd0;
    if (fila == fila_1) begin
      row_idx = 2'd0;
    end else if (fila == fila_2) begin
      row_idx = 2'd1;
    end else if (fila == fila_3) begin
      row_idx = 2'd2;
    end else if (fila == fila_4) begin
      row_idx = 2'd3;
    end else begin
      row_hit = 1'b0;
    end

    col_hit = 1'b1;
    col_idx = 2'd0;
    if (col == col_1) begin
      col_idx = 2'd0;
    end else if (col == col_2) begin
      col_idx = 2'd1;
    end else if (col == col_3) begin
      col_idx = 2'd2;
    end else if (col == col_4) begin
      col_idx = 2'd3;
    end else begin
      col_hit = 1'b0;
    end

    valid = row_hit && col_hit;
    code  = valid ? key_lookup(row_idx, col_idx) : KEY_NONE;
  end

endmodule

// File: rtl/driver_teclado.sv
// 4x4 keypad scanner: rotates the column drive, holds it while a row is active, reports new presses.
// Optional debounce window enabled with `define DRV_TECLADO_DEBOUNCE_EN.
module driver_teclado
  import drv_teclado_pkg::*;
#(
  parameter logic [3:0] col_3  = 4'b0100,
  parameter logic [3:0] fila_1 = 4'b0001,
  parameter logic [3:0] col_4  = 4'b1000,
  parameter logic [3:0] fila_2 = 4'b0010,
  parameter logic [3:0] fila_3 = 4'b0100,
  parameter logic [3:0] col_1  = 4'b0001,
  parameter logic [3:0] fila_4 = 4'b1000,
  parameter logic [3:0] col_2  = 4'b0010,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [4:0] digito,
  output logic       cambio_digito
);

`ifdef DRV_TECLADO_DEBOUNCE_EN
  localparam int DEB_TARGET = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
`else
  localparam int DEB_TARGET = 1;
`endif

  // Counter is sized for the configured window in both builds so its reset value is always defined.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 2);

  logic [3:0]       col_q       = col_1;
  logic [4:0]       digito_q    = KEY_NONE;
  logic             cambio_q    = 1'b0;
  scan_state_t      state_q     = ST_SCAN;
  logic [CNT_W-1:0] cnt_q       = '0;
  logic [3:0]       last_fila_q = 4'b0000;

  logic [4:0] key_code;
  logic       key_valid;

  teclado_decode #(
    .col_3  (col_3),
    .fila_1 (fila_1),
    .col_4  (col_4),
    .fila_2 (fila_2),
    .fila_3 (fila_3),
    .col_1  (col_1),
    .fila_4 (fila_4),
    .col_2  (col_2)
  ) u_decode (
    .col   (col_q),
    .fila  (fila),
    .code  (key_code),
    .valid (key_valid)
  );

  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] n;
    if (c == col_1) begin
      n = col_2;
    end else if (c == col_2) begin
      n = col_3;
    end else if (c == col_3) begin
      n = col_4;
    end else begin
      n = col_1;
    end
    return n;
  endfunction

  // ST_SCAN means fila was 0 on the previous edge; any nonzero fila freezes the column until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= col_1;
      digito_q    <= KEY_NONE;
      cambio_q    <= 1'b0;
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      last_fila_q <= 4'b0000;
    end else begin
      cambio_q <= 1'b0;
      if (fila == 4'b0000) begin
        col_q   <= next_col(col_q);
        state_q <= ST_SCAN;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_SCAN: begin
            if (key_valid) begin
              last_fila_q <= fila;
              if (DEB_TARGET == 1) begin
                digito_q <= key_code;
                cambio_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= ST_HELD;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= ST_COUNT;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          ST_COUNT: begin
            if (key_valid && (fila == last_fila_q)) begin
              if (int'(cnt_q) + 1 >= DEB_TARGET) begin
                digito_q <= key_code;
                cambio_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= ST_HELD;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (key_valid) begin
              last_fila_q <= fila;
              cnt_q       <= CNT_W'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= ST_HELD;
            end
          end
          default: begin
            state_q <= ST_HELD;
          end
        endcase
      end
    end
  end

  assign col           = col_q;
  assign digito        = digito_q;
  assign cambio_digito = cambio_q;

endmodule

// File: tb/tb_driver_teclado.sv
// Self-checking bench for driver_teclado: directed keypad scenarios plus random row activity
// compared against a keypad-level reference model (scan position, last key, pulse).
module tb_driver_teclado;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] fila = 4'b0000;
  logic [3:0] col;
  logic [4:0] digito;
  logic       cambio_digito;

  int checks = 0;
  int errors = 0;

  int m_idx       = 0;
  int m_dig       = 31;
  bit m_pulse     = 1'b0;
  bit m_prev_zero = 1'b1;

  int key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int pulses;

  driver_teclado dut (
    .clk           (clk),
    .rst           (rst),
    .fila          (fila),
    .col           (col),
    .digito        (digito),
    .cambio_digito (cambio_digito)
  );

  always #5 clk = ~clk;

  function automatic int row_of(input logic [3:0] f);
    int r;
    int n;
    r = -1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (f[i]) begin
        n++;
        r = i;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  // Keypad behaviour: release advances the scan, a fresh single-row press latches the key.
  task automatic model_step(input logic [3:0] f, input bit r);
    int row;
    if (r) begin
      m_idx       = 0;
      m_dig       = 31;
      m_pulse     = 1'b0;
      m_prev_zero = 1'b1;
    end else begin
      m_pulse = 1'b0;
      if (f == 4'b0000) begin
        m_idx       = (m_idx + 1) % 4;
        m_prev_zero = 1'b1;
      end else begin
        row = row_of(f);
        if (row >= 0 && m_prev_zero) begin
          m_dig   = key_tab[row * 4 + m_idx];
          m_pulse = 1'b1;
        end
        m_prev_zero = 1'b0;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".col"}, 8'(col), 8'(1 << m_idx));
    check_val({tag, ".digito"}, 8'(digito), 8'(m_dig));
    check_val({tag, ".pulse"}, 8'(cambio_digito), 8'(m_pulse));
  endtask

  task automatic apply_stimulus(input logic [3:0] f, input bit r);
    rst  = r;
    fila = f;
    @(posedge clk);
    model_step(f, r);
    #1;
    if (cambio_digito === 1'b1) pulses++;
  endtask

  task automatic scan_to(input int idx);
    for (int k = 0; k < 8 && m_idx != idx; k++) begin
      apply_stimulus(4'b0000, 1'b0);
    end
  endtask

  initial begin
    pulses = 0;
    #1;
    check_val("powerup.col", 8'(col), 8'(4'b0001));
    check_val("powerup.digito", 8'(digito), 8'd31);
    check_val("powerup.pulse", 8'(cambio_digito), 8'd0);

    apply_stimulus(4'b0000, 1'b1);
    check_output("reset");
    check_val("reset.col_const", 8'(col), 8'(4'b0001));

    for (int k = 0; k < 5; k++) begin
      apply_stimulus(4'b0000, 1'b0);
      check_output("scan");
    end

    scan_to(1);
    check_val("press2.pre_col", 8'(col), 8'(4'b0010));
    apply_stimulus(4'b0001, 1'b0);
    check_output("press2");
    check_val("press2.digito_const", 8'(digito), 8'd2);
    check_val("press2.pulse_const", 8'(cambio_digito), 8'd1);
    check_val("press2.col_held", 8'(col), 8'(4'b0010));
    apply_stimulus(4'b0000, 1'b0);
    check_output("press2.release");
    check_val("press2.scan_resumes", 8'(col), 8'(4'b0100));

    scan_to(3);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(4'b0100, 1'b0);
      check_output("holdC");
      check_val("holdC.col_const", 8'(col), 8'(4'b1000));
    end
    check_val("holdC.digito_const", 8'(digito), 8'd12);
    check_val("holdC.pulse_count", 8'(pulses), 8'd1);

    apply_stimulus(4'b0000, 1'b0);
    scan_to(0);
    pulses = 0;
    apply_stimulus(4'b1000, 1'b0);
    check_output("star");
    check_val("star.digito_const", 8'(digito), 8'd14);
    apply_stimulus(4'b0000, 1'b0);
    scan_to(2);
    apply_stimulus(4'b1000, 1'b0);
    check_output("hash");
    check_val("hash.digito_const", 8'(digito), 8'd15);
    check_val("star_hash.pulse_count", 8'(pulses), 8'd2);

    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0011, 1'b0);
    check_output("multirow");
    check_val("multirow.pulse_const", 8'(cambio_digito), 8'd0);
    check_val("multirow.digito_const", 8'(digito), 8'd15);

    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b0);
    check_output("rowswap.first");
    apply_stimulus(4'b0010, 1'b0);
    check_output("rowswap.second");
    check_val("rowswap.no_pulse", 8'(cambio_digito), 8'd0);

    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0001, 1'b1);
    check_output("rst_vs_press");
    check_val("rst_vs_press.digito_const", 8'(digito), 8'd31);
    check_val("rst_vs_press.pulse_const", 8'(cambio_digito), 8'd0);

    for (int k = 0; k < 400; k++) begin
      int sel;
      logic [3:0] f;
      bit r;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        f = 4'b0000;
      end else if (sel < 8) begin
        f = 4'(1 << $urandom_range(0, 3));
      end else begin
        f = 4'($urandom_range(0, 15));
      end
      r = ($urandom_range(0, 49) == 0);
      apply_stimulus(f, r);
      check_output("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/driver_teclado.md
DRIVER_TECLADO -- requirements
Module: driver_teclado

Interface
REQ-001 SHALL declare parameters in this exact positional order: col_3, fila_1, col_4, fila_2, fila_3, col_1, fila_4, col_2.
REQ-002 col_1 default 4'b0001, meaning: drive pattern for keypad column 1.
REQ-003 col_2 default 4'b0010, meaning: drive pattern for column 2.
REQ-004 col_3 default 4'b0100, meaning: drive pattern for column 3.
REQ-005 col_4 default 4'b1000, meaning: drive pattern for column 4.
REQ-006 fila_1..fila_4 defaults 4'b0001/0010/0100/1000, meaning: row-input codes for rows 1..4.
REQ-007 clk  input  1  system clock, rising edge; one clock; reset is synchronous and active-high.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 fila  input  4  keypad row sense; 0 = no key.
REQ-010 col  output  4  column drive pattern, registered.
REQ-011 digito  output  5  code of last accepted key, registered.
REQ-012 cambio_digito  output  1  one-cycle pulse when digito is updated with a new press.

Function
REQ-013 Scan: while idle, col SHALL advance one step per clock, col_1 -> col_2 -> col_3 -> col_4 -> col_1.
REQ-014 A press is valid when fila equals exactly one of fila_1..fila_4; the key is the current col pattern combined with that row.
REQ-015 Key map, by row/column: r1 = 1,2,3,A; r2 = 4,5,6,B; r3 = 7,8,9,C; r4 = *,0,#,D.
REQ-016 Codes: digits 0-9 map to 5'd0-9; A-D map to 10-13; * maps to 14; # maps to 15; 5'd31 means no key.
REQ-017 Accept: on the rising edge where a valid press is sampled and fila was 0 on the previous edge, digito SHALL load the code and cambio_digito SHALL be 1 for exactly the following cycle (latency 1).
REQ-018 While fila != 0, col SHALL hold its value and no further pulse is generated; scan resumes on the first edge with fila == 0.
REQ-019 Holding a key SHALL NOT repeat the pulse; only a new 0 -> valid transition produces one.
REQ-020 A nonzero, non-one-hot fila (multiple rows) SHALL be ignored: digito unchanged, no pulse, col held.
REQ-021 A change from one valid row to another without fila returning to 0 SHALL NOT be accepted.
REQ-022 digito SHALL hold its last value indefinitely until the next accepted press.

Reset
REQ-023 On a rst-sampled edge: col = col_1, digito = 5'd31, cambio_digito = 0, previous-fila flag = idle, debounce counter = 0.
REQ-024 rst SHALL take priority over a simultaneous press.
REQ-025 All registers SHALL power up (initial value) equal to their reset values, so the block operates without rst asserted.

Configuration
REQ-026 With DRV_TECLADO_DEBOUNCE_EN defined, a press is accepted only after fila holds the same valid value for DEBOUNCE_CYCLES consecutive edges (parameter, default 4); col is held while counting, and any change restarts the count.
REQ-027 Without DRV_TECLADO_DEBOUNCE_EN, a press is accepted on the first sampled edge, so single-cycle fila pulses register.

Structure
REQ-028 The key-code constants (KEY_0..KEY_D, KEY_STAR, KEY_HASH, KEY_NONE=31) SHALL go in package drv_teclado_pkg.
REQ-029 Key decode SHALL be one sub-module, teclado_decode (combinational: col, fila -> code, valid).

Verification
REQ-030 Reset, then fila=0 for 5 cycles -> col sequence 0001,0010,0100,1000,0001; digito=31; cambio_digito=0.
REQ-031 fila=4'b0001 for 1 cycle while col=0010 -> next cycle digito=2 and cambio_digito=1 for one cycle; col held during the press, then scan resumes.
REQ-032 fila=4'b0100 held 10 cycles at col=1000 -> digito=12, exactly one pulse, col constant for 10 cycles.
REQ-033 fila=4'b1000 at col=0001 then at col=0100 (with fila=0 between) -> digito 14 then 15, two pulses.
REQ-034 fila=4'b0011 -> no pulse; digito unchanged.
REQ-035 rst asserted on the same edge as a valid press -> reset values result and no pulse.
